mx_operand_packer: RTL and testbench

Operand feeder for one MX tensor-core PE operand port (A or B; one instance per port). Accepts a 64-bit data stream plus a sideband shared exponent, assembles one operand block per precision mode and presents it with a valid/ready handshake. The outputs connect directly to the PE wrapper operand inputs: `*_INT8`/`*_FP8`/`*_FP6`/`*_FP4`, `shared_exp_*`, `*_valid`/`*_ready`. Also counts the programmed number of blocks and signals completion.

---
 rtl/mx_operand_packer_if.sv | 43 ++++
 rtl/mx_operand_packer.sv | 166 ++++++++++++++++
 tb/tb_mx_operand_packer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mx_operand_packer_if.sv
// Stream, configuration and operand-block signals between the operand
// packer and its surroundings.
// The slave view belongs to the packer and the master view to whatever feeds and drains it.
interface mx_operand_packer_if;
    logic         start;
    logic [1:0]   prec_mode;
    logic [1:0]   FP_mode;
    logic [15:0]  num_blocks;

    logic [63:0]  in_data;
    logic [7:0]   in_exp;
    logic         in_valid;
    logic         in_ready;

    logic [63:0]  out_int8;
    logic [191:0] out_fp6;
    logic [255:0] out_fp8;
    logic [255:0] out_fp4;
    logic [7:0]   out_shared_exp;
    logic         out_valid;
    logic         out_ready;

    logic         busy;
    logic         done;

    modport slave (
        input  start, prec_mode, FP_mode, num_blocks,
        input  in_data, in_exp, in_valid,
        output in_ready,
        output out_int8, out_fp6, out_fp8, out_fp4, out_shared_exp, out_valid,
        input  out_ready,
        output busy, done
    );

    modport master (
        output start, prec_mode, FP_mode, num_blocks,
        output in_data, in_exp, in_valid,
        input  in_ready,
        input  out_int8, out_fp6, out_fp8, out_fp4, out_shared_exp, out_valid,
        output out_ready,
        input  busy, done
    );
endinterface

// File: rtl/mx_operand_packer.sv
// Operand feeder for one MX PE operand port: gathers 1, 3 or 4 beats of
// 64 bits into an operand block (first beat in the MSBs), tags it with the
// shared exponent of its first beat and hands it over with valid/ready.
// Runs for a programmed number of blocks, then pulses done.
module mx_operand_packer (
    input  logic               clk_i,
    input  logic               rst_i,
    mx_operand_packer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_HOLD,
        ST_FIN
    } state_t;

    state_t       state_reg;
    logic [1:0]   last_beat_reg;   // beats per block minus one
    logic [15:0]  num_blocks_reg;
    logic [15:0]  blk_cnt_reg;
    logic [1:0]   beat_cnt_reg;
    logic [255:0] buf_reg;
    logic [255:0] buf_next;
    logic [7:0]   exp_reg;
    logic         in_ready_reg;
    logic         out_valid_reg;
    logic         busy_reg;
    logic         done_reg;

    logic [1:0]   mode_last_beat;
    logic         beat_accept;
    logic [1:0]   slot_sel;
    logic [63:0]  slot_next [4];

    // Decode beats per block from the mode presented with start.
    always_comb begin
        mode_last_beat = 2'd0;
        case (bus.prec_mode)
            2'b01: begin
                case (bus.FP_mode)
                    2'b11, 2'b10: mode_last_beat = 2'd3;   // FP8
                    default:      mode_last_beat = 2'd2;   // FP6
                endcase
            end
            2'b11:   mode_last_beat = 2'd3;                // FP4
            default: mode_last_beat = 2'd0;                // INT8
        endcase
    end

    // in_ready_reg is high exactly in FILL, so it doubles as the state gate.
    assign beat_accept = in_ready_reg & bus.in_valid;

    // Beat k of a B-beat block lands in 64-bit slot B-1-k; slot 0 is the LSBs.
    assign slot_sel = last_beat_reg - beat_cnt_reg;

    // First beat of a block also wipes every other slot, so slots above the
    // payload width read as zero and nothing leaks from a wider earlier block.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign slot_next[gi] =
                !beat_accept              ? buf_reg[gi*64 +: 64] :
                (slot_sel == 2'(gi))      ? bus.in_data :
                (beat_cnt_reg == 2'd0)    ? 64'd0 :
                                            buf_reg[gi*64 +: 64];
        end
    endgenerate

    assign buf_next = {slot_next[3], slot_next[2], slot_next[1], slot_next[0]};

    // Operand buffer register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_reg <= '0;
        end else begin
            buf_reg <= buf_next;
        end
    end

    // Run control FSM with registered handshake and status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            last_beat_reg  <= 2'd0;
            num_blocks_reg <= 16'd0;
            blk_cnt_reg    <= 16'd0;
            beat_cnt_reg   <= 2'd0;
            exp_reg        <= 8'd0;
            in_ready_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        last_beat_reg  <= mode_last_beat;
                        num_blocks_reg <= bus.num_blocks;
                        blk_cnt_reg    <= 16'd0;
                        beat_cnt_reg   <= 2'd0;
                        busy_reg       <= 1'b1;
                        if (bus.num_blocks != 16'd0) begin
                            state_reg    <= ST_FILL;
                            in_ready_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_FIN;
                        end
                    end
                end
                ST_FILL: begin
                    if (beat_accept) begin
                        if (beat_cnt_reg == 2'd0) begin
                            exp_reg <= bus.in_exp;
                        end
                        if (beat_cnt_reg == last_beat_reg) begin
                            beat_cnt_reg  <= 2'd0;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                            state_reg     <= ST_HOLD;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 2'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        blk_cnt_reg   <= blk_cnt_reg + 16'd1;
                        if (blk_cnt_reg + 16'd1 == num_blocks_reg) begin
                            // done rises with FIN so it trails the last handshake by one cycle.
                            done_reg  <= 1'b1;
                            state_reg <= ST_FIN;
                        end else begin
                            in_ready_reg <= 1'b1;
                            state_reg    <= ST_FILL;
                        end
                    end
                end
                ST_FIN: begin
                    // An empty run arrives here without done raised; it gets one extra FIN cycle.
                    if (done_reg) begin
                        done_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready       = in_ready_reg;
    assign bus.out_valid      = out_valid_reg;
    assign bus.out_shared_exp = exp_reg;
    assign bus.out_int8       = buf_reg[63:0];
    assign bus.out_fp6        = buf_reg[191:0];
    assign bus.out_fp8        = buf_reg;
    assign bus.out_fp4        = buf_reg;
    assign bus.busy           = busy_reg;
    assign bus.done           = done_reg;
endmodule

// File: tb/tb_mx_operand_packer.sv
// Bench for mx_operand_packer: a table of single-block vectors, hand-written
// empty-run and reset sequences, and randomized runs against a block-level model.
module tb_mx_operand_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mx_operand_packer_if bus ();

    mx_operand_packer dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    localparam logic [63:0] PA = 64'hA0A1A2A3A4A5A6A7;
    localparam logic [63:0] PB = 64'hB0B1B2B3B4B5B6B7;
    localparam logic [63:0] PC = 64'hC0C1C2C3C4C5C6C7;
    localparam logic [63:0] PD = 64'hD0D1D2D3D4D5D6D7;

    typedef struct packed {
        logic [1:0]        pm;
        logic [1:0]        fm;
        logic [2:0]        nbeats;
        logic [3:0][63:0]  data;     // data[k] is beat k
        logic [3:0][7:0]   ex;       // ex[k] goes with beat k
        logic [3:0]        stall;    // cycles out_ready stays low in HOLD
        logic [255:0]      exp_buf;
        logic [7:0]        exp_sexp;
    } vec_t;

    vec_t vecs [8];

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic int beats_for(input logic [1:0] pm, input logic [1:0] fm);
        if (pm == 2'b01) return (fm == 2'b11 || fm == 2'b10) ? 4 : 3;
        if (pm == 2'b11) return 4;
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_block(input string tag, input logic [255:0] b, input logic [7:0] sx);
        chk({tag, "_fp8"}, bus.out_fp8, b);
        chk({tag, "_fp4"}, bus.out_fp4, b);
        chk({tag, "_fp6"}, 256'(bus.out_fp6), 256'(b[191:0]));
        chk({tag, "_int8"}, 256'(bus.out_int8), 256'(b[63:0]));
        chk({tag, "_sexp"}, 256'(bus.out_shared_exp), 256'(sx));
    endtask

    // One-block run from a table entry; checks handshake timing, stall stability and done.
    task automatic apply_vec(input vec_t v, input int idx);
        bus.start = 1'b1; bus.prec_mode = v.pm; bus.FP_mode = v.fm; bus.num_blocks = 16'd1;
        tick();
        bus.start = 1'b0; bus.prec_mode = ~v.pm; bus.FP_mode = ~v.fm; bus.num_blocks = 16'd7;
        chk("vec_busy_rise", 256'(bus.busy), 256'(1));
        for (int k = 0; k < int'(v.nbeats); k++) begin
            chk("vec_fill_in_ready", 256'(bus.in_ready), 256'(1));
            chk("vec_fill_out_valid", 256'(bus.out_valid), 256'(0));
            bus.in_valid = 1'b1; bus.in_data = v.data[k]; bus.in_exp = v.ex[k];
            tick();
        end
        bus.in_data = {$urandom, $urandom}; bus.in_exp = 8'($urandom);
        bus.out_ready = 1'b0;
        for (int s = 0; s <= int'(v.stall); s++) begin
            chk("vec_hold_out_valid", 256'(bus.out_valid), 256'(1));
            chk("vec_hold_in_ready", 256'(bus.in_ready), 256'(0));
            chk("vec_hold_done", 256'(bus.done), 256'(0));
            check_block("vec_hold", v.exp_buf, v.exp_sexp);
            if (s < int'(v.stall)) tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        chk("vec_done_pulse", 256'(bus.done), 256'(1));
        chk("vec_done_out_valid", 256'(bus.out_valid), 256'(0));
        chk("vec_done_busy", 256'(bus.busy), 256'(1));
        tick();
        chk("vec_done_end", 256'(bus.done), 256'(0));
        chk("vec_busy_fall", 256'(bus.busy), 256'(0));
        chk("vec_idle_in_ready", 256'(bus.in_ready), 256'(0));
        $display("vec %0d mode=%b/%b beats=%0d block=%h exp=%h", idx, v.pm, v.fm, v.nbeats, v.exp_buf, v.exp_sexp);
    endtask

    // Randomized run against a block-level model: each block is the
    // concatenation of its accepted beats, first beat most significant.
    task automatic run(input logic [1:0] pm, input logic [1:0] fm, input int nb,
                       input bit toggle, input int vprob, input int rprob);
        int b, phase, beat, blocks, cyc;
        logic [255:0] acc;
        logic [7:0]   sx;
        b = beats_for(pm, fm);
        bus.start = 1'b1; bus.prec_mode = pm; bus.FP_mode = fm; bus.num_blocks = 16'(nb);
        tick();
        bus.start = 1'b0;
        phase = 1; beat = 0; blocks = 0; cyc = 0; acc = '0; sx = '0;
        while (phase != 3 && cyc < 4000) begin
            chk("run_in_ready", 256'(bus.in_ready), 256'(phase == 1));
            chk("run_out_valid", 256'(bus.out_valid), 256'(phase == 2));
            chk("run_busy", 256'(bus.busy), 256'(1));
            chk("run_done_early", 256'(bus.done), 256'(0));
            if (phase == 2) check_block("run", acc, sx);
            bus.in_valid   = toggle ? cyc[0] : (int'($urandom_range(99)) < vprob);
            bus.in_data    = {$urandom, $urandom};
            bus.in_exp     = 8'($urandom);
            bus.out_ready  = (int'($urandom_range(99)) < rprob);
            bus.start      = ($urandom_range(7) == 0);
            bus.prec_mode  = 2'($urandom);
            bus.FP_mode    = 2'($urandom);
            bus.num_blocks = 16'($urandom);
            if (phase == 1 && bus.in_valid) begin
                if (beat == 0) begin
                    acc = {192'd0, bus.in_data};
                    sx  = bus.in_exp;
                end else begin
                    acc = {acc[191:0], bus.in_data};
                end
                beat++;
                if (beat == b) begin
                    phase = 2;
                    beat  = 0;
                end
            end else if (phase == 2 && bus.out_ready) begin
                blocks++;
                $display("run mode=%b/%b block %0d/%0d data=%h exp=%h", pm, fm, blocks, nb, acc, sx);
                phase = (blocks == nb) ? 3 : 1;
            end
            tick();
            cyc++;
        end
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        chk("run_finished_in_budget", 256'(phase == 3), 256'(1));
        chk("run_done_pulse", 256'(bus.done), 256'(1));
        chk("run_done_busy", 256'(bus.busy), 256'(1));
        chk("run_done_in_ready", 256'(bus.in_ready), 256'(0));
        chk("run_done_out_valid", 256'(bus.out_valid), 256'(0));
        tick();
        chk("run_done_end", 256'(bus.done), 256'(0));
        chk("run_busy_fall", 256'(bus.busy), 256'(0));
    endtask

    initial begin
        bus.start = 1'b0; bus.prec_mode = 2'b00; bus.FP_mode = 2'b00; bus.num_blocks = 16'd0;
        bus.in_data = '0; bus.in_exp = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;

        vecs[0] = '{pm:2'b00, fm:2'b00, nbeats:3'd1,
                    data:{64'h0, 64'h0, 64'h0, 64'h0102030405060708}, ex:{8'h0, 8'h0, 8'h0, 8'h7F},
                    stall:4'd0, exp_buf:{192'h0, 64'h0102030405060708}, exp_sexp:8'h7F};
        vecs[1] = '{pm:2'b10, fm:2'b00, nbeats:3'd1,
                    data:{64'h0, 64'h0, 64'h0, 64'h1111111111111111}, ex:{8'h0, 8'h0, 8'h0, 8'h80},
                    stall:4'd2, exp_buf:{192'h0, 64'h1111111111111111}, exp_sexp:8'h80};
        vecs[2] = '{pm:2'b01, fm:2'b10, nbeats:3'd4,
                    data:{64'hF3F3F3F3F3F3F3F3, 64'hF2F2F2F2F2F2F2F2, 64'hF1F1F1F1F1F1F1F1, 64'hF0F0F0F0F0F0F0F0},
                    ex:{8'h04, 8'h03, 8'h02, 8'h01}, stall:4'd10,
                    exp_buf:{64'hF0F0F0F0F0F0F0F0, 64'hF1F1F1F1F1F1F1F1, 64'hF2F2F2F2F2F2F2F2, 64'hF3F3F3F3F3F3F3F3},
                    exp_sexp:8'h01};
        vecs[3] = '{pm:2'b01, fm:2'b11, nbeats:3'd4,
                    data:{64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF},
                    ex:{8'hAA, 8'hBB, 8'hCC, 8'h5A}, stall:4'd1,
                    exp_buf:{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0},
                    exp_sexp:8'h5A};
        vecs[4] = '{pm:2'b01, fm:2'b00, nbeats:3'd3, data:{64'h0, PC, PB, PA},
                    ex:{8'h0, 8'h33, 8'h22, 8'h11}, stall:4'd0, exp_buf:{64'h0, PA, PB, PC}, exp_sexp:8'h11};
        vecs[5] = '{pm:2'b01, fm:2'b01, nbeats:3'd3, data:{64'h0, PB, PA, PC},
                    ex:{8'h0, 8'h99, 8'h99, 8'h44}, stall:4'd3, exp_buf:{64'h0, PC, PA, PB}, exp_sexp:8'h44};
        vecs[6] = '{pm:2'b11, fm:2'b01, nbeats:3'd4, data:{PA, PB, PC, PD},
                    ex:{8'h1, 8'h2, 8'h3, 8'hE0}, stall:4'd0, exp_buf:{PD, PC, PB, PA}, exp_sexp:8'hE0};
        vecs[7] = '{pm:2'b00, fm:2'b11, nbeats:3'd1, data:{PD, PC, PB, PA},
                    ex:{8'h0, 8'h0, 8'h0, 8'h3C}, stall:4'd1, exp_buf:{192'h0, PA}, exp_sexp:8'h3C};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 256'(bus.in_ready), 256'(0));
        chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
        chk("rst_busy", 256'(bus.busy), 256'(0));
        chk("rst_done", 256'(bus.done), 256'(0));
        chk("rst_buf", bus.out_fp8, 256'(0));
        chk("rst_sexp", 256'(bus.out_shared_exp), 256'(0));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);

        // Empty run, with a second start while busy that must be ignored.
        bus.start = 1'b1; bus.prec_mode = 2'b00; bus.num_blocks = 16'd0;
        tick();
        bus.start = 1'b0;
        chk("zero_busy", 256'(bus.busy), 256'(1));
        chk("zero_done_c1", 256'(bus.done), 256'(0));
        chk("zero_in_ready_c1", 256'(bus.in_ready), 256'(0));
        bus.start = 1'b1; bus.num_blocks = 16'd3;
        tick();
        bus.start = 1'b0;
        chk("zero_done_c2", 256'(bus.done), 256'(1));
        chk("zero_out_valid_c2", 256'(bus.out_valid), 256'(0));
        chk("zero_in_ready_c2", 256'(bus.in_ready), 256'(0));
        tick();
        chk("zero_done_end", 256'(bus.done), 256'(0));
        chk("zero_busy_fall", 256'(bus.busy), 256'(0));
        tick();
        chk("zero_restart_ignored_in_ready", 256'(bus.in_ready), 256'(0));
        chk("zero_restart_ignored_busy", 256'(bus.busy), 256'(0));
        $display("zero-block run and ignored start complete");

        // Reset in FILL after 2 of 4 beats aborts immediately.
        bus.start = 1'b1; bus.prec_mode = 2'b01; bus.FP_mode = 2'b10; bus.num_blocks = 16'd1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1; bus.in_data = {$urandom | 32'h1, $urandom}; bus.in_exp = 8'h77;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("pre_rst_in_ready", 256'(bus.in_ready), 256'(1));
        rst = 1'b1;
        #1;
        chk("abort_in_ready", 256'(bus.in_ready), 256'(0));
        chk("abort_busy", 256'(bus.busy), 256'(0));
        chk("abort_out_valid", 256'(bus.out_valid), 256'(0));
        chk("abort_done", 256'(bus.done), 256'(0));
        chk("abort_buf", bus.out_fp8, 256'(0));
        chk("abort_sexp", 256'(bus.out_shared_exp), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_done", 256'(bus.done), 256'(0));
        apply_vec(vecs[2], 2);
        $display("reset abort and restart complete");

        // Randomized runs.
        run(2'b11, 2'b00, 3, 1'b1, 100, 100);
        run(2'b00, 2'b00, 2, 1'b0, 100, 100);
        run(2'b01, 2'b10, 5, 1'b0, 60, 50);
        run(2'b01, 2'b01, 6, 1'b0, 70, 40);
        run(2'b10, 2'b11, 8, 1'b0, 50, 70);
        for (int r = 0; r < 6; r++) begin
            run(2'($urandom), 2'($urandom), int'($urandom_range(10, 1)), 1'b0,
                int'($urandom_range(90, 30)), int'($urandom_range(90, 30)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
